// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin arbiter in front of one pipelined Wishbone slave.
// The grant is registered and the granted path is combinational. Outstanding requests are capped, and hung cycles time out.
module wb_rr_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    output logic          o_m0_stall,
    output logic [DW-1:0] o_m0_data,
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic          o_m1_stall,
    output logic [DW-1:0] o_m1_data,
    output logic          o_s_cyc,
    output logic          o_s_stb,
    output logic          o_s_we,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_data,
    input  logic          i_s_ack,
    input  logic          i_s_stall,
    input  logic [DW-1:0] i_s_data
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam bit            TMO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          sel_m1;
    logic          g_cyc;
    logic          g_stb;
    logic          g_stall;
    logic          cnt_ack;
    logic          accept;

    // Mux of the master that currently owns the slave
    assign sel_m1  = (state_q == GNT1);
    assign g_cyc   = sel_m1 ? i_m1_cyc : i_m0_cyc;
    assign g_stb   = g_cyc & (sel_m1 ? i_m1_stb : i_m0_stb) & (outst_q < OUTST_MAX);
    assign g_stall = i_s_stall | (outst_q == OUTST_MAX);
    assign cnt_ack = i_s_ack & (outst_q != '0);
    assign accept  = g_stb & ~i_s_stall;

    assign o_m0_data = i_s_data;
    assign o_m1_data = i_s_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            outst_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        outst_d    = outst_q;
        tmo_d      = tmo_q;
        o_s_cyc    = 1'b0;
        o_s_stb    = 1'b0;
        o_s_we     = 1'b0;
        o_s_addr   = '0;
        o_s_data   = '0;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m1_err   = 1'b0;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;

        case (state_q)
            IDLE: begin
                outst_d = '0;
                tmo_d   = '0;
                // last_q==1 means m1 won most recently, so m0 takes a tie
                if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                o_s_cyc  = g_cyc;
                o_s_stb  = g_stb;
                o_s_we   = sel_m1 ? i_m1_we   : i_m0_we;
                o_s_addr = sel_m1 ? i_m1_addr : i_m0_addr;
                o_s_data = sel_m1 ? i_m1_data : i_m0_data;
                if (sel_m1) begin
                    o_m1_stall = g_stall;
                    o_m1_ack   = cnt_ack;
                end else begin
                    o_m0_stall = g_stall;
                    o_m0_ack   = cnt_ack;
                end

                if (!g_cyc) begin
                    state_d = IDLE;
                    outst_d = '0;
                    tmo_d   = '0;
                end else begin
                    if (accept && !cnt_ack) begin
                        outst_d = outst_q + OW'(1);
                    end else if (!accept && cnt_ack) begin
                        outst_d = outst_q - OW'(1);
                    end

                    if (i_s_ack || (outst_q == '0)) begin
                        tmo_d = '0;
                    end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                        state_d = ABORT;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            ABORT: begin
                o_m0_err = ~last_q;
                o_m1_err = last_q;
                state_d  = IDLE;
                outst_d  = '0;
                tmo_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: a delayed-ack slave model and a scoreboard of expected master acks.
// Instance a uses TIMEOUT=8. Instance b has the timeout disabled so that long ack delays can be tested.
module tb_wb_rr_arbiter;

    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        s_ack = 0, s_stall = 0;
    logic [31:0] s_rdata = '0;

    logic        a_m0_ack, a_m0_err, a_m0_stall, a_m1_ack, a_m1_err, a_m1_stall;
    logic        a_s_cyc, a_s_stb, a_s_we;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic        b_m0_ack, b_m0_err, b_m0_stall, b_m1_ack, b_m1_err, b_m1_stall;
    logic        b_s_cyc, b_s_stb, b_s_we;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;

    wb_rr_arbiter #(.AW(32), .DW(32), .MAX_OUTST(4), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
        .o_m0_ack(a_m0_ack), .o_m0_err(a_m0_err), .o_m0_stall(a_m0_stall), .o_m0_data(a_m0_rdata),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
        .o_m1_ack(a_m1_ack), .o_m1_err(a_m1_err), .o_m1_stall(a_m1_stall), .o_m1_data(a_m1_rdata),
        .o_s_cyc(a_s_cyc), .o_s_stb(a_s_stb), .o_s_we(a_s_we), .o_s_addr(a_s_addr), .o_s_data(a_s_wdata),
        .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_rdata)
    );

    wb_rr_arbiter #(.AW(32), .DW(32), .MAX_OUTST(4), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
        .o_m0_ack(b_m0_ack), .o_m0_err(b_m0_err), .o_m0_stall(b_m0_stall), .o_m0_data(b_m0_rdata),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
        .o_m1_ack(b_m1_ack), .o_m1_err(b_m1_err), .o_m1_stall(b_m1_stall), .o_m1_data(b_m1_rdata),
        .o_s_cyc(b_s_cyc), .o_s_stb(b_s_stb), .o_s_we(b_s_we), .o_s_addr(b_s_addr), .o_s_data(b_s_wdata),
        .i_s_ack(s_ack), .i_s_stall(s_stall), .i_s_data(s_rdata)
    );

    // Observed view: the instance under test is picked by sel_b
    logic sel_b = 1'b0;
    logic m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall, s_cyc, s_stb, s_we;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    assign m0_ack   = sel_b ? b_m0_ack   : a_m0_ack;
    assign m0_err   = sel_b ? b_m0_err   : a_m0_err;
    assign m0_stall = sel_b ? b_m0_stall : a_m0_stall;
    assign m0_rdata = sel_b ? b_m0_rdata : a_m0_rdata;
    assign m1_ack   = sel_b ? b_m1_ack   : a_m1_ack;
    assign m1_err   = sel_b ? b_m1_err   : a_m1_err;
    assign m1_stall = sel_b ? b_m1_stall : a_m1_stall;
    assign m1_rdata = sel_b ? b_m1_rdata : a_m1_rdata;
    assign s_cyc    = sel_b ? b_s_cyc    : a_s_cyc;
    assign s_stb    = sel_b ? b_s_stb    : a_s_stb;
    assign s_we     = sel_b ? b_s_we     : a_s_we;
    assign s_addr   = sel_b ? b_s_addr   : a_s_addr;
    assign s_wdata  = sel_b ? b_s_wdata  : a_s_wdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    int unsigned cyc_n = 0;
    int unsigned due_q[$];
    logic [31:0] adr_q[$];
    int unsigned ack_dly = 1;
    bit          hold_ack = 0;
    bit          spur = 0;
    bit          watch_m1 = 0;
    int          m1_viol = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Slave model: ack each accepted request ack_dly cycles later and return addr^KEY
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && s_cyc && s_stb && !s_stall) begin
                due_q.push_back(cyc_n + ack_dly);
                adr_q.push_back(s_addr);
            end
            @(posedge clk);
            #1;
            cyc_n++;
            s_ack = 1'b0;
            if (!hold_ack && due_q.size() > 0 && due_q[0] <= cyc_n) begin
                s_ack   = 1'b1;
                s_rdata = adr_q[0] ^ KEY;
                void'(due_q.pop_front());
                void'(adr_q.pop_front());
            end else if (spur) begin
                s_ack   = 1'b1;
                s_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic take_ack(input logic m, input logic [31:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("ack_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("ack_master", m, e.m);
            check("ack_data", d, e.d);
        end
    endtask

    // Monitor: every ack pops the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m0_ack || m1_ack) check("dual_ack", m0_ack & m1_ack, 0);
                if (m0_ack) take_ack(1'b0, m0_rdata);
                if (m1_ack) take_ack(1'b1, m1_rdata);
                if (watch_m1 && !m1_stall) m1_viol++;
            end
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        due_q.delete();
        adr_q.delete();
        hold_ack = 0;
        spur     = 0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_scyc"}, s_cyc, 0);
        check({tag, "_sstb"}, s_stb, 0);
        check({tag, "_m0stall"}, m0_stall, 1);
        check({tag, "_m1stall"}, m1_stall, 1);
        check({tag, "_acks"}, {m0_ack, m1_ack}, 0);
        check({tag, "_errs"}, {m0_err, m1_err}, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        s_stall = 0;
        tick();
        tick();
        reset = 0;
        clear_sb();
        smp();
        chk_reset(tag);
        tick();
    endtask

    task automatic drive_req(input logic m, input logic stb, input logic [31:0] a, input logic we);
        if (m) begin
            m1_stb = stb; m1_addr = a; m1_we = we; m1_wdata = a + 32'h1111;
        end else begin
            m0_stb = stb; m0_addr = a; m0_we = we; m0_wdata = a + 32'h1111;
        end
    endtask

    // Present one request (cyc already high) until accepted, then drop stb
    task automatic issue(input logic m, input logic [31:0] a, input logic we, input int budget);
        bit done = 0;
        drive_req(m, 1'b1, a, we);
        for (int i = 0; i < budget && !done; i++) begin
            smp();
            if (!(m ? m1_stall : m0_stall)) begin
                done = 1;
                exp_q.push_back('{m: m, d: a ^ KEY});
                check("issue_saddr", s_addr, a);
                check("issue_swe", s_we, we);
                check("issue_swdata", s_wdata, a + 32'h1111);
            end
            tick();
        end
        drive_req(m, 1'b0, a, we);
        check("issue_accept", done, 1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            smp();
            i++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, first_ack, acc5, n_slv, err_at, last_ack, n_after;
        logic full_stall;

        // 1: single m0 read, stb-without-cyc ignored, slave stall propagates
        sel_b = 0;
        do_reset("t1_rst");
        ack_dly = 1; watch_m1 = 1; m1_viol = 0;
        m0_stb = 1; m0_addr = 32'h100;
        smp(); check("t1_nocyc_scyc", s_cyc, 0);
        tick(); smp(); check("t1_nocyc_stall", m0_stall, 1);
        tick(); m0_cyc = 1; s_stall = 1;
        smp(); check("t1_lat_idle", s_cyc, 0);
        tick(); smp();
        check("t1_gnt_scyc", s_cyc, 1);
        check("t1_sstall_prop", m0_stall, 1);
        tick(); s_stall = 0;
        smp();
        check("t1_accept", m0_stall, 0);
        check("t1_saddr", s_addr, 32'h100);
        exp_q.push_back('{m: 1'b0, d: 32'h100 ^ KEY});
        tick(); m0_stb = 0;
        smp(); check("t1_ack", m0_ack, 1);
        tick(); m0_cyc = 0;
        smp(); tick();
        watch_m1 = 0;
        check("t1_m1_stall", m1_viol, 0);
        check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

        // 2: simultaneous requests, then alternation through IDLE
        do_reset("t2_rst");
        m0_cyc = 1; m1_cyc = 1;
        smp(); check("t2_idle_stall", {m0_stall, m1_stall}, 2'b11);
        tick(); smp();
        check("t2_g0_scyc", s_cyc, 1);
        check("t2_g0_stalls", {m0_stall, m1_stall}, 2'b01);
        tick();
        issue(1'b0, 32'h2000, 1'b0, 5);
        wait_drain("t2_drain0", 10);
        tick(); m0_cyc = 0;
        smp(); check("t2_drop_scyc", s_cyc, 0);
        tick(); smp();
        check("t2_idle_scyc", s_cyc, 0);
        check("t2_idle_m1stall", m1_stall, 1);
        tick(); smp();
        check("t2_g1_scyc", s_cyc, 1);
        check("t2_g1_stalls", {m0_stall, m1_stall}, 2'b10);
        tick(); m0_cyc = 1;
        issue(1'b1, 32'h2100, 1'b1, 5);
        wait_drain("t2_drain1", 10);
        tick(); m1_cyc = 0;
        smp(); tick(); m1_cyc = 1;
        smp(); check("t2_tie_idle", {m0_stall, m1_stall}, 2'b11);
        tick(); smp();
        check("t2_tie_m0", {m0_stall, m1_stall}, 2'b01);
        tick(); m0_cyc = 0; m1_cyc = 0;
        tick();

        // 3: outstanding cap with 10-cycle ack delay (timeout disabled instance)
        sel_b = 1;
        do_reset("t3_rst");
        ack_dly = 10;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h3000; m1_we = 0;
        n_acc = 0; first_ack = -1; acc5 = -1; n_slv = 0;
        for (int c = 0; c < 40 && n_acc < 6; c++) begin
            smp();
            if (m1_ack && first_ack < 0) first_ack = c;
            if (first_ack < 0 && s_cyc && s_stb && !s_stall) n_slv++;
            if (!m1_stall) begin
                exp_q.push_back('{m: 1'b1, d: m1_addr ^ KEY});
                n_acc++;
                if (n_acc == 5) acc5 = c;
            end
            tick();
            m1_addr = 32'h3000 + 32'(n_acc * 4);
            if (n_acc == 6) m1_stb = 0;
        end
        check("t3_slave_reqs", n_slv, 4);
        check("t3_first_ack", first_ack, 11);
        check("t3_acc5", acc5, 12);
        wait_drain("t3_drain", 40);
        tick(); m1_cyc = 0; tick();

        // 4: timeout abort with TIMEOUT=8
        sel_b = 0;
        do_reset("t4_rst");
        hold_ack = 1;
        m0_cyc = 1;
        tick();
        m0_stb = 1; m0_addr = 32'h400;
        smp(); check("t4_accept", m0_stall, 0);
        tick(); m0_stb = 0;
        err_at = -1;
        for (int k = 1; k <= 12 && err_at < 0; k++) begin
            smp();
            if (m0_err) begin
                err_at = k;
                check("t4_err_scyc", s_cyc, 0);
                check("t4_err_stall", m0_stall, 1);
                check("t4_err_m1", m1_err, 0);
            end
            if (err_at < 0) tick();
        end
        check("t4_err_at", err_at, 9);
        tick(); smp();
        check("t4_err_pulse", m0_err, 0);
        check("t4_idle_scyc", s_cyc, 0);
        tick(); smp();
        check("t4_regrant_scyc", s_cyc, 1);
        check("t4_regrant_stall", m0_stall, 0);
        tick(); m0_cyc = 0; tick();

        // 5: ack + accept in the same cycle holds outst; spurious ack dropped
        do_reset("t5_rst");
        ack_dly = 2;
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h500; m0_we = 0;
        n_acc = 0; last_ack = -1; n_after = 0; full_stall = 0;
        for (int c = 0; c <= 10; c++) begin
            smp();
            if (m0_ack) last_ack = c;
            if (!m0_stall) begin
                exp_q.push_back('{m: 1'b0, d: m0_addr ^ KEY});
                n_acc++;
                if (c > 6) n_after++;
            end
            if (c == 9) full_stall = m0_stall;
            if (c == 6) hold_ack = 1;
            if (c == 10) hold_ack = 0;
            tick();
            m0_addr = 32'h500 + 32'(n_acc * 4);
            if (c == 10) m0_stb = 0;
        end
        check("t5_last_ack", last_ack, 6);
        check("t5_accepts_to_full", n_after, 2);
        check("t5_full_stall", full_stall, 1);
        wait_drain("t5_drain", 20);
        tick(); smp();
        spur = 1;
        tick(); smp();
        check("t5_spur_noack", m0_ack, 0);
        spur = 0;
        tick();
        issue(1'b0, 32'h5F0, 1'b0, 5);
        wait_drain("t5_after_spur", 10);
        tick(); m0_cyc = 0; tick();

        // 6: reset in GNT1 with three outstanding
        do_reset("t6_rst");
        hold_ack = 1;
        m1_cyc = 1;
        tick();
        m1_stb = 1; m1_addr = 32'h600;
        for (int i = 0; i < 3; i++) begin
            smp(); check("t6_acc", m1_stall, 0);
            tick();
        end
        reset = 1; m0_cyc = 1;
        tick();
        reset = 0;
        clear_sb();
        smp(); chk_reset("t6_mid");
        tick(); smp();
        check("t6_m0_wins", {m0_stall, m1_stall}, 2'b01);
        tick(); m0_cyc = 0; m1_cyc = 0; m1_stb = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
